// File: rtl/filter_mode_sequencer.sv
// rtl/filter_mode_sequencer.sv - selects the camera filter path and sequences blur fill, padding and output valid
// FSEQ_STATS_EN builds the frame_cnt statistics counter; otherwise frame_cnt is tied to 0.
module filter_mode_sequencer #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int PAD           = 2,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [2:0]  mode_sel,
  input  logic        vga_vs,
  input  logic        pix_valid,
  output logic [2:0]  active_mode,
  output logic        bright_en,
  output logic        blur_en,
  output logic        edge_en,
  output logic        pad_zero,
  output logic        blur_wr,
  output logic        out_valid,
  output logic [8:0]  row_idx,
  output logic [9:0]  col_idx,
  output logic        overrun,
  output logic [15:0] frame_cnt
);

  localparam logic [2:0] M_PASS   = 3'b000;
  localparam logic [2:0] M_BRIGHT = 3'b001;
  localparam logic [2:0] M_BLUR   = 3'b101;
  localparam logic [2:0] M_EDGE   = 3'b110;

  localparam int FILL_LEN = PAD * H_ACTIVE + PAD;
  localparam int SW       = $clog2(STABLE_CYCLES + 1);
  localparam int FW       = $clog2(FILL_LEN + 1);

  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [FW-1:0] FILL_LAST  = FW'(FILL_LEN - 1);
  localparam logic [8:0]    ROW_LAST   = 9'(V_ACTIVE - 1);
  localparam logic [9:0]    COL_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [8:0]    ROW_PAD_LO = 9'(PAD);
  localparam logic [8:0]    ROW_PAD_HI = 9'(V_ACTIVE - PAD);
  localparam logic [9:0]    COL_PAD_LO = 10'(PAD);
  localparam logic [9:0]    COL_PAD_HI = 10'(H_ACTIVE - PAD);

  typedef enum logic [1:0] {S_PASS, S_PENDING, S_FILL, S_RUN} state_t;

  state_t          state;
  state_t          prior_state;
  logic [2:0]      mode_s1, mode_s2, mode_last;
  logic [SW-1:0]   stab_cnt;
  logic [2:0]      candidate;
  logic            vs_s1, vs_s2, vs_s3;
  logic [FW-1:0]   fill_cnt;
  logic [8:0]      row_cnt;
  logic [9:0]      col_cnt;
  logic            frame_full;

  logic            frame_start;
  logic [2:0]      next_active;
  logic            pix_blur;
  logic            out_ok;
  logic [8:0]      cur_row;
  logic [9:0]      cur_col;
  logic            is_last;
  logic            is_over;
  logic            border;

  function automatic logic [2:0] decode_mode(input logic [2:0] code);
    case (code)
      M_BRIGHT, M_BLUR, M_EDGE: return code;
      default:                  return M_PASS;
    endcase
  endfunction

  assign frame_start = vs_s3 & ~vs_s2;

  // Mode the pixel in this cycle belongs to: a frame_start in PENDING switches it immediately.
  assign next_active = (state == S_PENDING && frame_start) ? candidate : active_mode;
  assign pix_blur    = (next_active == M_BLUR);

  assign cur_row = frame_start ? 9'd0  : row_cnt;
  assign cur_col = frame_start ? 10'd0 : col_cnt;
  assign is_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
  assign is_over = ~frame_start & frame_full;
  assign border  = (cur_row < ROW_PAD_LO) || (cur_row >= ROW_PAD_HI) ||
                   (cur_col < COL_PAD_LO) || (cur_col >= COL_PAD_HI);

  always_comb begin
    out_ok = 1'b0;
    case (state)
      S_RUN:     out_ok = ~frame_start;
      S_PENDING: out_ok = ~frame_start & (prior_state == S_RUN);
      S_FILL:    out_ok = ~frame_start & (fill_cnt == FILL_LAST);
      default:   out_ok = 1'b0;
    endcase
  end

  // Synchronisers and mode stability filter
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      mode_s1   <= 3'b000;
      mode_s2   <= 3'b000;
      mode_last <= 3'b000;
      stab_cnt  <= '0;
      candidate <= M_PASS;
      vs_s1     <= 1'b1;
      vs_s2     <= 1'b1;
      vs_s3     <= 1'b1;
    end else begin
      mode_s1 <= mode_sel;
      mode_s2 <= mode_s1;
      vs_s1   <= vga_vs;
      vs_s2   <= vs_s1;
      vs_s3   <= vs_s2;
      if (mode_s2 != mode_last) begin
        mode_last <= mode_s2;
        stab_cnt  <= SW'(1);
      end else if (stab_cnt != STABLE_MAX) begin
        stab_cnt <= stab_cnt + SW'(1);
      end else begin
        candidate <= decode_mode(mode_last);
      end
    end
  end

  // Mode FSM, enables and blur pipeline sequencing
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= S_PASS;
      prior_state <= S_PASS;
      active_mode <= M_PASS;
      fill_cnt    <= '0;
      bright_en   <= 1'b0;
      blur_en     <= 1'b0;
      edge_en     <= 1'b0;
      blur_wr     <= 1'b0;
      out_valid   <= 1'b0;
      pad_zero    <= 1'b0;
    end else begin
      bright_en <= (next_active == M_BRIGHT);
      blur_en   <= (next_active == M_BLUR);
      edge_en   <= (next_active == M_EDGE);
      blur_wr   <= pix_valid & pix_blur;
      out_valid <= pix_valid & pix_blur & out_ok;
      pad_zero  <= blur_en & pix_valid & border;
      case (state)
        S_PASS: begin
          if (candidate != active_mode) begin
            prior_state <= S_PASS;
            state       <= S_PENDING;
          end
        end
        S_RUN: begin
          if (frame_start) begin
            state    <= S_FILL;
            fill_cnt <= pix_valid ? FW'(1) : '0;
          end else if (candidate != active_mode) begin
            prior_state <= S_RUN;
            state       <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (frame_start) begin
            active_mode <= candidate;
            fill_cnt    <= pix_valid ? FW'(1) : '0;
            state       <= (candidate == M_BLUR) ? S_FILL : S_PASS;
          end else if (candidate == active_mode) begin
            state <= prior_state;
          end
        end
        S_FILL: begin
          if (frame_start) begin
            fill_cnt <= pix_valid ? FW'(1) : '0;
          end else if (pix_valid) begin
            // The pixel completing the fill count is the first valid blur output.
            if (fill_cnt == FILL_LAST) state <= S_RUN;
            else fill_cnt <= fill_cnt + FW'(1);
          end
        end
        default: state <= S_PASS;
      endcase
    end
  end

  // Active-window row/col tracking
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      row_idx    <= '0;
      col_idx    <= '0;
      frame_full <= 1'b0;
      overrun    <= 1'b0;
    end else if (pix_valid) begin
      if (is_over) begin
        overrun <= 1'b1;
      end else begin
        row_idx <= cur_row;
        col_idx <= cur_col;
        if (is_last) begin
          frame_full <= 1'b1;
          row_cnt    <= cur_row;
          col_cnt    <= cur_col;
        end else if (cur_col == COL_LAST) begin
          frame_full <= 1'b0;
          row_cnt    <= cur_row + 9'd1;
          col_cnt    <= 10'd0;
        end else begin
          frame_full <= 1'b0;
          row_cnt    <= cur_row;
          col_cnt    <= cur_col + 10'd1;
        end
      end
    end else if (frame_start) begin
      row_cnt    <= '0;
      col_cnt    <= '0;
      frame_full <= 1'b0;
    end
  end

`ifdef FSEQ_STATS_EN
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_filter_mode_sequencer.sv
// tb/tb_filter_mode_sequencer.sv - directed table-driven bench for filter_mode_sequencer
module tb_filter_mode_sequencer;

  localparam int H    = 16;
  localparam int V    = 8;
  localparam int P    = 2;
  localparam int ST   = 16;
  localparam int FILL = P * H + P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mode_sel;
  logic        vga_vs;
  logic        pix_valid;
  logic [2:0]  active_mode;
  logic        bright_en, blur_en, edge_en, pad_zero, blur_wr, out_valid;
  logic [8:0]  row_idx;
  logic [9:0]  col_idx;
  logic        overrun;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_frames = 0;
  bit ov_seen = 0;
  bit wr_seen = 0;

  typedef struct {
    logic [2:0] code;
    logic [2:0] act;
    logic       br;
    logic       bl;
    logic       ed;
  } mode_vec_t;

  mode_vec_t tbl [8];

  filter_mode_sequencer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PAD(P), .STABLE_CYCLES(ST)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .mode_sel(mode_sel), .vga_vs(vga_vs),
    .pix_valid(pix_valid), .active_mode(active_mode), .bright_en(bright_en),
    .blur_en(blur_en), .edge_en(edge_en), .pad_zero(pad_zero), .blur_wr(blur_wr),
    .out_valid(out_valid), .row_idx(row_idx), .col_idx(col_idx), .overrun(overrun),
    .frame_cnt(frame_cnt)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) ov_seen = 1;
    if (blur_wr === 1'b1) wr_seen = 1;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle_mode(input logic [2:0] m);
    mode_sel = m;
    repeat (ST + 8) tick();
  endtask

  task automatic vs_pulse();
    vga_vs = 1'b0;
    repeat (4) tick();
    vga_vs = 1'b1;
    repeat (3) tick();
    exp_frames++;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      tick();
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{3'b000, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{3'b001, 3'b001, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{3'b010, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{3'b101, 3'b101, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{3'b011, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{3'b110, 3'b110, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{3'b100, 3'b000, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{3'b111, 3'b000, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    mode_sel = 3'b000;
    vga_vs = 1'b1;
    pix_valid = 1'b0;
    repeat (3) tick();
    chk("reset active_mode", active_mode, 3'b000);
    chk("reset enables", {bright_en, blur_en, edge_en}, 3'b000);
    chk("reset stream", {pad_zero, blur_wr, out_valid, overrun}, 4'b0000);
    chk("reset row/col", {row_idx, col_idx}, 19'd0);
    chk("reset frame_cnt", frame_cnt, 16'd0);

    rst_n = 1'b1;
    tick();
    ov_seen = 0;
    wr_seen = 0;
    vs_pulse();
    send(H * V);
    vs_pulse();
    send(H * V);
    chk("pass active_mode", active_mode, 3'b000);
    chk("pass enables", {bright_en, blur_en, edge_en}, 3'b000);
    chk("pass out_valid never", ov_seen, 1'b0);
    chk("pass blur_wr never", wr_seen, 1'b0);

    for (int i = 0; i < 8; i++) begin
      settle_mode(tbl[i].code);
      vs_pulse();
      chk($sformatf("tbl%0d active_mode", i), active_mode, tbl[i].act);
      chk($sformatf("tbl%0d enables", i), {bright_en, blur_en, edge_en},
          {tbl[i].br, tbl[i].bl, tbl[i].ed});
      send(H * V);
    end

    vs_pulse();
    send(20);
    mode_sel = 3'b101;
    repeat (ST + 8) tick();
    chk("pending active_mode held", active_mode, 3'b000);
    chk("pending blur_en held", blur_en, 1'b0);
    vs_pulse();
    chk("blur active_mode", active_mode, 3'b101);
    chk("blur blur_en", blur_en, 1'b1);
    for (int k = 1; k <= H * V; k++) begin
      int r;
      int c;
      logic bz;
      r = (k - 1) / H;
      c = (k - 1) % H;
      bz = (r < P) || (r >= V - P) || (c < P) || (c >= H - P);
      pix_valid = 1'b1;
      tick();
      chk($sformatf("pad_zero r%0d c%0d", r, c), pad_zero, bz);
      chk($sformatf("out_valid px%0d", k), out_valid, (k >= FILL));
      chk($sformatf("row_idx px%0d", k), row_idx, r);
      chk($sformatf("col_idx px%0d", k), col_idx, c);
      chk($sformatf("blur_wr px%0d", k), blur_wr, 1'b1);
    end
    pix_valid = 1'b0;
    tick();
    chk("idle pad_zero", pad_zero, 1'b0);
    chk("idle out_valid", out_valid, 1'b0);

    mode_sel = 3'b110;
    repeat (8) tick();
    mode_sel = 3'b101;
    repeat (ST + 8) tick();
    vs_pulse();
    chk("glitch active_mode", active_mode, 3'b101);
    chk("glitch enables", {bright_en, blur_en, edge_en}, 3'b010);
    send(1);
    chk("refill first out_valid", out_valid, 1'b0);
    send(FILL + 5);
    chk("refill done out_valid", out_valid, 1'b1);

    settle_mode(3'b110);
    chk("cancel pending active_mode", active_mode, 3'b101);
    settle_mode(3'b101);
    send(1);
    chk("cancel no refill out_valid", out_valid, 1'b1);
    vs_pulse();
    chk("cancel active_mode", active_mode, 3'b101);
    chk("cancel enables", {bright_en, blur_en, edge_en}, 3'b010);

    send(5);
    chk("pre-fs col_idx", col_idx, 10'd4);
    vga_vs = 1'b0;
    tick();
    tick();
    pix_valid = 1'b1;
    tick();
    chk("fs pixel row_idx", row_idx, 9'd0);
    chk("fs pixel col_idx", col_idx, 10'd0);
    tick();
    chk("after fs col_idx", col_idx, 10'd1);
    pix_valid = 1'b0;
    vga_vs = 1'b1;
    exp_frames++;
    repeat (3) tick();

    send(H * V - 2);
    chk("full frame overrun", overrun, 1'b0);
    chk("full frame row/col", {row_idx, col_idx}, {9'(V - 1), 10'(H - 1)});
    send(1);
    chk("overrun set", overrun, 1'b1);
    chk("overrun row/col held", {row_idx, col_idx}, {9'(V - 1), 10'(H - 1)});
    send(1);
    chk("overrun row/col still held", {row_idx, col_idx}, {9'(V - 1), 10'(H - 1)});
    vs_pulse();
    chk("overrun sticky", overrun, 1'b1);

`ifdef FSEQ_STATS_EN
    chk("frame_cnt", frame_cnt, 16'(exp_frames));
`else
    chk("frame_cnt", frame_cnt, 16'd0);
`endif

    send(3);
    pix_valid = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async reset active_mode", active_mode, 3'b000);
    chk("async reset col/overrun", {col_idx, overrun, blur_en}, 12'd0);
    chk("async reset frame_cnt", frame_cnt, 16'd0);
    pix_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
